rgb_pwm_array: RTL and testbench
================================

RGB_PWM_ARRAY -- requirements
Module: rgb_pwm_array

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of RGB LED channels, 1..8.
REQ-002 SHALL have parameter PWM_W, default 8: duty and PWM counter width, 4..12.
REQ-003 SHALL have parameter STEP, default 16: duty increment/decrement per button press, 1..2^PWM_W-1.
REQ-004 SHALL have parameter TICK_DIV, default 125000: clk cycles per button-sample tick, >=2.
REQ-005 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port btn  in  3  raw buttons: btn[1] select, btn[2] up, btn[3] down; asynchronous to clk.
REQ-008 SHALL have port sel_out  out  $clog2(3*N_CH)  currently selected component index.
REQ-009 SHALL have ports r_out, g_out and b_out, each out N_CH wide: PWM drive, bit i drives channel i.

Function
REQ-010 SHALL index components as k = 3*ch + color, with color 0=R, 1=G, 2=B.
REQ-011 SHALL run a prescaler from 0 to TICK_DIV-1, wrapping to 0 and asserting a one-cycle tick on each wrap.
REQ-012 SHALL synchronise each btn bit through 2 flops, and update a debounced level only when two consecutive tick samples agree.
REQ-013 SHALL treat a 0->1 change of the debounced level as one press event, lasting one cycle; holding a button yields exactly one event.
REQ-014 SHALL increment sel on a btn[1] event, wrapping from 3*N_CH-1 to 0.
REQ-015 SHALL add STEP to duty[sel] on a btn[2] event, saturating at 2^PWM_W-1.
REQ-016 SHALL subtract STEP from duty[sel] on a btn[3] event, saturating at 0.
REQ-017 SHALL leave duty unchanged when btn[2] and btn[3] events occur in the same cycle.
REQ-018 SHALL apply a duty change to the old sel when a duty event and a btn[1] event coincide; sel then advances.
REQ-019 SHALL run one shared free-running PWM counter from 0 to 2^PWM_W-2, giving a period of 2^PWM_W-1 cycles.
REQ-020 SHALL drive an output high iff counter < active duty: duty 0 gives constant low, and duty 2^PWM_W-1 gives constant high.
REQ-021 SHALL copy each duty register into its active (shadow) register only in the cycle the PWM counter wraps to 0; no mid-period glitches.
REQ-022 SHALL make sel_out equal to the sel register, with zero latency.

Reset
REQ-023 SHALL, with rst high at a clk edge, clear the prescaler, PWM counter, sel, all duty and shadow registers, synchronisers and debounced levels to 0.
REQ-024 SHALL hold r_out/g_out/b_out = 0 and sel_out = 0 from the first edge with rst high until the first edge after rst falls.
REQ-025 SHALL, on reset mid-press, discard the pending event; a button still held after reset SHALL produce one event once debounced.

Configuration
REQ-026 SHALL, with RGB_BREATHE_EN defined, add port breathe (in, 1); when breathe=1, each output uses min(ramp, shadow duty).
REQ-027 SHALL step ramp by 1 per tick as a triangle wave 0 -> 2^PWM_W-1 -> 0; ramp resets to 0 and holds 0 while breathe=0.
REQ-028 SHALL, without RGB_BREATHE_EN, omit the breathe port and ramp logic, and outputs use shadow duty directly.

Structure
REQ-029 SHALL place color index constants (R/G/B = 0/1/2) and a component-index-to-(channel, color) helper in package rgb_pwm_pkg.
REQ-030 SHALL implement synchroniser, debounce and edge detect in sub-module btn_debounce, instantiated once per button bit.

Verification (N_CH=2, PWM_W=8, STEP=16, TICK_DIV=4)
REQ-031 SHALL cover: rst held 3 cycles, then released -> all outputs 0, sel_out=0, no toggling for 600 cycles.
REQ-032 SHALL cover: 4 btn[2] presses on sel 0 -> r_out[0] high exactly 64 of 255 cycles per period, first applied at a counter wrap.
REQ-033 SHALL cover: 17 btn[2] presses -> duty saturates at 255 and r_out[0] is constant 1; then 20 btn[3] presses -> 0 and constant low.
REQ-034 SHALL cover: 6 btn[1] presses -> sel_out 1,2,3,4,5,0; a btn[2] press at sel 4 -> only g_out[1] is active.
REQ-035 SHALL cover: btn[2] and btn[3] asserted together for 3 ticks -> duty unchanged; a 1-tick glitch on btn[2] -> no event.
REQ-036 SHALL cover, with RGB_BREATHE_EN: duty 128, breathe=1 -> on-time tracks ramp, capped at 128 high-cycles per period, until ramp falls.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// Shared constants and helpers for the RGB PWM array: color indices and the
// component-index decoder (k = 3*ch + color).
package rgb_pwm_pkg;

  localparam int unsigned COLOR_R  = 0;
  localparam int unsigned COLOR_G  = 1;
  localparam int unsigned COLOR_B  = 2;
  localparam int unsigned N_COLORS = 3;

  typedef struct packed {
    int unsigned ch;
    int unsigned color;
  } comp_idx_t;

  function automatic comp_idx_t comp_decode(input int unsigned k);
    comp_idx_t idx;
    idx.ch    = k / N_COLORS;
    idx.color = k % N_COLORS;
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button input: 2-flop synchroniser, tick-sampled debounce and a one-cycle
// press pulse on each debounced 0->1 transition.
module btn_debounce (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic samp_q, samp_d;
  logic level_q, level_d;
  logic agree;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    // samp_q holds the previous tick sample; the level moves only when the
    // current sample matches it.
    agree   = tick && (sync2_q == samp_q);
    samp_d  = tick ? sync2_q : samp_q;
    level_d = agree ? sync2_q : level_q;
    press   = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      samp_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      samp_q  <= samp_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/rgb_pwm_array.sv
// Button-controlled array of RGB PWM channels with one shared PWM counter.
// Optional breathing effect is enabled by defining RGB_BREATHE_EN.
module rgb_pwm_array
  import rgb_pwm_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int PWM_W    = 8,
  parameter int STEP     = 16,
  parameter int TICK_DIV = 125000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:1]                    btn,
`ifdef RGB_BREATHE_EN
  input  logic                          breathe,
`endif
  output logic [$clog2(3*N_CH)-1:0]     sel_out,
  output logic [N_CH-1:0]               r_out,
  output logic [N_CH-1:0]               g_out,
  output logic [N_CH-1:0]               b_out
);

  localparam int N_COMP = 3 * N_CH;
  localparam int SEL_W  = $clog2(N_COMP);
  localparam int PRE_W  = $clog2(TICK_DIV);

  localparam logic [PWM_W-1:0] DUTY_MAX = '1;
  localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'((1 << PWM_W) - 2);
  localparam logic [PWM_W-1:0] STEP_V   = PWM_W'(STEP);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_COMP - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic [3:1]       press;

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [PWM_W-1:0] duty_q   [N_COMP];
  logic [PWM_W-1:0] duty_d   [N_COMP];
  logic [PWM_W-1:0] shadow_q [N_COMP];
  logic [PWM_W-1:0] shadow_d [N_COMP];
  logic [PWM_W-1:0] eff_duty [N_COMP];

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic             cnt_wrap;

  logic [PWM_W-1:0] cur_duty;
  logic [PWM_W:0]   up_sum;
  logic [PWM_W-1:0] up_val, dn_val;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  for (genvar b = 1; b <= 3; b++) begin : g_btn
    btn_debounce u_db (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .btn_raw (btn[b]),
      .press   (press[b])
    );
  end

  always_comb begin
    cur_duty = duty_q[sel_q];
    up_sum   = {1'b0, cur_duty} + {1'b0, STEP_V};
    up_val   = up_sum[PWM_W] ? DUTY_MAX : up_sum[PWM_W-1:0];
    dn_val   = (cur_duty < STEP_V) ? '0 : cur_duty - STEP_V;
  end

  // Duty changes use the pre-advance sel; opposing up/down events cancel.
  always_comb begin
    sel_d  = sel_q;
    duty_d = duty_q;
    if (press[2] != press[3]) begin
      duty_d[sel_q] = press[2] ? up_val : dn_val;
    end
    if (press[1]) begin
      sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
    end
  end

  always_comb begin
    cnt_wrap = (cnt_q == CNT_LAST);
    cnt_d    = cnt_wrap ? '0 : cnt_q + PWM_W'(1);
    shadow_d = cnt_wrap ? duty_q : shadow_q;
  end

`ifdef RGB_BREATHE_EN
  logic [PWM_W-1:0] ramp_q, ramp_d;
  logic             ramp_dn_q, ramp_dn_d;

  always_comb begin
    ramp_d    = ramp_q;
    ramp_dn_d = ramp_dn_q;
    if (!breathe) begin
      ramp_d    = '0;
      ramp_dn_d = 1'b0;
    end else if (tick) begin
      if (!ramp_dn_q) begin
        if (ramp_q == DUTY_MAX) begin
          ramp_dn_d = 1'b1;
          ramp_d    = ramp_q - PWM_W'(1);
        end else begin
          ramp_d    = ramp_q + PWM_W'(1);
        end
      end else begin
        if (ramp_q == '0) begin
          ramp_dn_d = 1'b0;
          ramp_d    = ramp_q + PWM_W'(1);
        end else begin
          ramp_d    = ramp_q - PWM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ramp_q    <= '0;
      ramp_dn_q <= 1'b0;
    end else begin
      ramp_q    <= ramp_d;
      ramp_dn_q <= ramp_dn_d;
    end
  end
`endif

  always_comb begin
    for (int k = 0; k < N_COMP; k++) begin
      eff_duty[k] = shadow_q[k];
`ifdef RGB_BREATHE_EN
      if (breathe && (ramp_q < shadow_q[k])) eff_duty[k] = ramp_q;
`endif
    end
  end

  always_comb begin
    comp_idx_t idx;
    logic      on;
    idx   = '0;
    on    = 1'b0;
    r_out = '0;
    g_out = '0;
    b_out = '0;
    for (int unsigned k = 0; k < N_COMP; k++) begin
      idx = comp_decode(k);
      on  = (cnt_q < eff_duty[k]);
      case (idx.color)
        COLOR_R: r_out[idx.ch] = on;
        COLOR_G: g_out[idx.ch] = on;
        COLOR_B: b_out[idx.ch] = on;
        default: ;
      endcase
    end
  end

  assign sel_out = sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
      sel_q <= '0;
      for (int k = 0; k < N_COMP; k++) begin
        duty_q[k]   <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_array.sv
// Bench for rgb_pwm_array: directed button sequences, a period/phase model of
// the PWM outputs checked every cycle, and hand-computed on-time counts.
module tb_rgb_pwm_array;

  localparam int N_CH     = 2;
  localparam int PWM_W    = 8;
  localparam int STEP     = 16;
  localparam int TICK_DIV = 4;
  localparam int N_COMP   = 3 * N_CH;
  localparam int PERIOD   = 255;
  localparam int DMAX     = 255;

  localparam logic [3:1] B_SEL  = 3'b001;
  localparam logic [3:1] B_UP   = 3'b010;
  localparam logic [3:1] B_DN   = 3'b100;
  localparam logic [3:1] B_BOTH = 3'b110;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:1]      btn = '0;
  logic            breathe = 1'b0;
  logic [2:0]      sel_out;
  logic [N_CH-1:0] r_out, g_out, b_out;

  int total = 0;
  int bad   = 0;

  // Model state: requested duties/sel, duties active this period, period phase
  int mdl_duty [N_COMP];
  int mdl_sel = 0;
  int act [N_COMP];
  int phase = 0;
  int pre = 0;
  int ramp_n = 0;
  bit chk_on = 0;
  bit sel_ok = 0;
  logic [2:0] exp_q[$];

  rgb_pwm_array #(
    .N_CH(N_CH), .PWM_W(PWM_W), .STEP(STEP), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
`ifdef RGB_BREATHE_EN
    .breathe (breathe),
`endif
    .sel_out (sel_out),
    .r_out   (r_out),
    .g_out   (g_out),
    .b_out   (b_out)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic int tri_val(input int n);
    int r;
    r = n % 510;
    return (r <= 255) ? r : 510 - r;
  endfunction

  function automatic int exp_out(input int k);
    int d;
    d = act[k];
`ifdef RGB_BREATHE_EN
    if (breathe && tri_val(ramp_n) < d) d = tri_val(ramp_n);
`endif
    return (phase < d) ? 1 : 0;
  endfunction

  function automatic int out_bit(input int k);
    case (k % 3)
      0:       return int'(r_out[k/3]);
      1:       return int'(g_out[k/3]);
      default: return int'(b_out[k/3]);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", name, got, want, $time);
    end
  endtask

  // model: phase advances each cycle, requested duties take effect at period start
  always @(posedge clk) begin
    if (rst) begin
      phase  = 0;
      pre    = 0;
      ramp_n = 0;
      for (int k = 0; k < N_COMP; k++) act[k] = 0;
    end else begin
      if (breathe) begin
        if (pre == TICK_DIV - 1) ramp_n++;
      end else begin
        ramp_n = 0;
      end
      pre = (pre == TICK_DIV - 1) ? 0 : pre + 1;
      if (phase == PERIOD - 1) begin
        phase = 0;
        for (int k = 0; k < N_COMP; k++) act[k] = mdl_duty[k];
      end else begin
        phase++;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    logic [N_CH-1:0] er, eg, eb;
    if (chk_on) begin
      for (int c = 0; c < N_CH; c++) begin
        er[c] = exp_out(3*c + 0) != 0;
        eg[c] = exp_out(3*c + 1) != 0;
        eb[c] = exp_out(3*c + 2) != 0;
      end
      check("r_out", 32'(r_out), 32'(er));
      check("g_out", 32'(g_out), 32'(eg));
      check("b_out", 32'(b_out), 32'(eb));
      if (sel_ok) check("sel_out", 32'(sel_out), 32'(mdl_sel));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_model(input logic [3:1] m);
    if (m[2] && !m[3])
      mdl_duty[mdl_sel] = (mdl_duty[mdl_sel] + STEP > DMAX) ? DMAX : mdl_duty[mdl_sel] + STEP;
    else if (m[3] && !m[2])
      mdl_duty[mdl_sel] = (mdl_duty[mdl_sel] < STEP) ? 0 : mdl_duty[mdl_sel] - STEP;
    if (m[1]) mdl_sel = (mdl_sel + 1) % N_COMP;
  endtask

  // start presses early in a period so the event lands before the next wrap
  task automatic wait_window();
    int g;
    g = 0;
    while ((phase < 2 || phase > 150) && g < 400) begin
      step();
      g++;
    end
    if (g >= 400) check("phase_window_timeout", g, 0);
  endtask

  task automatic press(input logic [3:1] m, input int hold);
    wait_window();
    sel_ok = 0;
    btn = m;
    apply_model(m);
    repeat (hold) step();
    btn = '0;
    repeat (24) step();
    sel_ok = 1;
  endtask

  task automatic press_n(input logic [3:1] m, input int n);
    for (int i = 0; i < n; i++) press(m, 24);
  endtask

  task automatic glitch_up();
    wait_window();
    btn[2] = 1'b1;
    repeat (TICK_DIV) step();
    btn = '0;
    repeat (24) step();
  endtask

  task automatic count_high(input int k, output int n);
    int g;
    g = 0;
    n = 0;
    while (phase != 0 && g < 400) begin
      step();
      g++;
    end
    if (g >= 400) check("period_start_timeout", g, 0);
    repeat (PERIOD) begin
      n += out_bit(k);
      step();
    end
  endtask

  task automatic do_reset(input int cycles);
    sel_ok = 0;
    rst = 1'b1;
    for (int k = 0; k < N_COMP; k++) mdl_duty[k] = 0;
    mdl_sel = 0;
    step();
    sel_ok = 1;
    repeat (cycles - 1) step();
    rst = 1'b0;
  endtask

  initial begin
    int n, hi, maxn;
    for (int k = 0; k < N_COMP; k++) mdl_duty[k] = 0;

    do_reset(3);
    chk_on = 1;
    check("rst_sel", 32'(sel_out), 0);
    check("rst_rgb", 32'({r_out, g_out, b_out}), 0);

    hi = 0;
    repeat (600) begin
      step();
      if (|{r_out, g_out, b_out}) hi++;
    end
    check("idle_quiet", hi, 0);

    press_n(B_UP, 4);
    count_high(0, n); check("r0_duty64", n, 64);
    count_high(1, n); check("g0_idle", n, 0);

    press_n(B_UP, 17);
    count_high(0, n); check("r0_sat_high", n, 255);
    press_n(B_DN, 20);
    count_high(0, n); check("r0_sat_low", n, 0);

    for (int i = 1; i <= 6; i++) begin
      exp_q.push_back(3'(i % 6));
      press(B_SEL, 24);
      check("sel_step", 32'(sel_out), 32'(exp_q.pop_front()));
    end
    press_n(B_SEL, 4);
    check("sel_at4", 32'(sel_out), 4);
    press(B_UP, 24);
    count_high(4, n); check("g1_duty16", n, 16);
    count_high(3, n); check("r1_idle", n, 0);
    count_high(5, n); check("b1_idle", n, 0);
    count_high(0, n); check("r0_idle", n, 0);

    press(B_BOTH, 12);
    count_high(4, n); check("both_no_change", n, 16);
    glitch_up();
    count_high(4, n); check("glitch_no_event", n, 16);

    press(B_SEL | B_UP, 24);
    check("sel_after_combo", 32'(sel_out), 5);
    count_high(4, n); check("combo_old_sel", n, 32);
    count_high(5, n); check("combo_new_sel_idle", n, 0);

    wait_window();
    sel_ok = 0;
    btn = B_UP;
    apply_model(B_UP);
    repeat (24) step();
    do_reset(3);
    sel_ok = 0;
    apply_model(B_UP);
    repeat (24) step();
    btn = '0;
    repeat (24) step();
    sel_ok = 1;
    check("held_rst_sel", 32'(sel_out), 0);
    count_high(0, n); check("held_rst_one_event", n, 16);
    count_high(5, n); check("held_rst_cleared", n, 0);

`ifdef RGB_BREATHE_EN
    press_n(B_UP, 7);
    count_high(0, n); check("breathe_base", n, 128);
    breathe = 1'b1;
    maxn = 0;
    for (int i = 0; i < 6; i++) begin
      count_high(0, n);
      if (i == 0) check("breathe_first_low", 32'(n < 128), 1);
      if (n > maxn) maxn = n;
    end
    check("breathe_cap", maxn, 128);
    breathe = 1'b0;
    repeat (10) step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
